// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access modes,
// the responder FSM state type, and the store byte-enable helper.
// No ports; imported by dmem_responder and dmem_load_align.
package dmem_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Byte enable for an access of the given width at lane offset a.
  // The caller supplies an offset already legal for the width.
  function automatic logic [3:0] lane_be(input logic [2:0] mode, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (mode)
      MODE_B, MODE_BU: be = 4'b0001 << a;
      MODE_H, MODE_HU: be = 4'b0011 << a;
      MODE_W:          be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a RAM word and
// sign- or zero-extends it according to funct3. Purely combinational.
// Ports: word (RAM word), mode (funct3), a (lane offset), data (load result).
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  mode,
  input  logic [1:0]  a,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[8*a +: 8];
    half_v = a[1] ? word[31:16] : word[15:0];
    data   = 32'h0;
    case (mode)
      MODE_B:  data = {{24{byte_v[7]}}, byte_v};
      MODE_H:  data = {{16{half_v[15]}}, half_v};
      MODE_W:  data = word;
      MODE_BU: data = {24'h0, byte_v};
      MODE_HU: data = {16'h0, half_v};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core load/store port: one request at a time
// over valid/ready, word-organised little-endian RAM, WAIT_CYCLES wait states.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_we/req_mode/
//   req_addr/req_wdata; rsp_valid/rsp_ready/rsp_rdata/rsp_err; busy.
// Option: DMEM_MISALIGN_TRAP_EN makes misaligned H/W accesses return an error;
//   otherwise the low address bits are forced to natural alignment.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              mode_ok;
  logic              acc_err;
  logic [1:0]        a_eff;
  logic [ADDR_W-3:0] word_idx;
  logic              commit;
  logic [3:0]        wr_be;
  logic [31:0]       wdata_lane;
  logic [31:0]       ld_data;

  // Access decode from the latched request.
  always_comb begin
    case (mode_q)
      MODE_B, MODE_H, MODE_W: mode_ok = 1'b1;
      MODE_BU, MODE_HU:       mode_ok = ~we_q;  // no unsigned stores
      default:                mode_ok = 1'b0;
    endcase

`ifdef DMEM_MISALIGN_TRAP_EN
    a_eff   = addr_q[1:0];
    acc_err = ~mode_ok
            | (((mode_q == MODE_H) || (mode_q == MODE_HU)) && addr_q[0])
            | ((mode_q == MODE_W) && (addr_q[1:0] != 2'b00));
`else
    // Misaligned accesses are silently rounded down to natural alignment.
    if ((mode_q == MODE_H) || (mode_q == MODE_HU)) begin
      a_eff = {addr_q[1], 1'b0};
    end else if (mode_q == MODE_W) begin
      a_eff = 2'b00;
    end else begin
      a_eff = addr_q[1:0];
    end
    acc_err = ~mode_ok;
`endif

    word_idx = addr_q[ADDR_W-1:2];
    commit   = (state_q == ACCESS) && (cnt_q == 4'd0);
    wr_be    = (commit && we_q && !acc_err) ? lane_be(mode_q, a_eff) : 4'b0000;

    // Replicate store data so every enabled lane sees its own source byte.
    case (mode_q)
      MODE_B:  wdata_lane = {4{wdata_q[7:0]}};
      MODE_H:  wdata_lane = {2{wdata_q[15:0]}};
      default: wdata_lane = wdata_q;
    endcase
  end

  dmem_load_align u_load_align (
    .word (mem[word_idx]),
    .mode (mode_q),
    .a    (a_eff),
    .data (ld_data)
  );

  // RAM contents are deliberately not reset. Writes only occur on the commit
  // edge, so a reset during ACCESS leaves the word untouched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) begin
        mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  // FSM next state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          mode_d  = req_mode;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'h0 : ld_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      mode_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
